// File: rtl/term_project_pkg.sv
// Shared types and constants for the dot-product calculator.
//   - FSM state enum, button bit positions, datapath widths
//   - Seven-segment glyphs (a..g, active-high) and a glyph lookup
//   - One double-dabble add-3 correction step
package term_project_pkg;

  localparam int unsigned ELEM_W     = 8;
  localparam int unsigned N_ELEM     = 8;
  localparam int unsigned ACC_W      = 20;
  localparam int unsigned BCD_DIGITS = 6;

  localparam int unsigned BTN_A = 0;
  localparam int unsigned BTN_B = 1;
  localparam int unsigned BTN_C = 2;
  localparam int unsigned BTN_D = 3;

  typedef enum logic [1:0] {StEnterA, StEnterB, StConvert, StShow} state_e;

  localparam logic [6:0] GLYPH_0     = 7'b1111110;
  localparam logic [6:0] GLYPH_1     = 7'b0110000;
  localparam logic [6:0] GLYPH_2     = 7'b1101101;
  localparam logic [6:0] GLYPH_3     = 7'b1111001;
  localparam logic [6:0] GLYPH_4     = 7'b0110011;
  localparam logic [6:0] GLYPH_5     = 7'b1011011;
  localparam logic [6:0] GLYPH_6     = 7'b1011111;
  localparam logic [6:0] GLYPH_7     = 7'b1110000;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1111011;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Digit code is {dp, value[3:0]}; any value above 9 renders blank.
  localparam logic [3:0] CODE_BLANK = 4'hF;

  function automatic logic [6:0] seg_glyph(input logic [3:0] v);
    case (v)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return GLYPH_BLANK;
    endcase
  endfunction

  // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_DIGITS*4-1:0] bcd_add3(input logic [BCD_DIGITS*4-1:0] b);
    logic [BCD_DIGITS*4-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[4*i+:4] > 4'd4) r[4*i+:4] = b[4*i+:4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/term_project_top_spec_seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner.
//   clk_i, rst_ni : clock, async active-low reset
//   codes_i       : per-digit {dp, value[3:0]}, digit 0 rightmost
//   com_o         : one-hot active-low digit select (registered)
//   data_o        : {a..g, dp} active-high (registered)
module seg7_scan
  import term_project_pkg::*;
#(
  parameter int unsigned ScanDiv = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [7:0][4:0] codes_i,
  output logic [7:0]      com_o,
  output logic [7:0]      data_o
);

  localparam int unsigned DivW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;

  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      digit_q, digit_d;
  logic [7:0]      com_q, com_d, data_q, data_d;
  logic [4:0]      cur;

  assign cur = codes_i[digit_q];

  always_comb begin
    div_d   = div_q + DivW'(1);
    digit_d = digit_q;
    if (div_q == DivW'(ScanDiv - 1)) begin
      div_d   = '0;
      digit_d = digit_q + 3'd1;
    end
    com_d  = ~(8'b1 << digit_q);
    data_d = {seg_glyph(cur[3:0]), cur[4]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      digit_q <= '0;
      com_q   <= 8'hFF;
      data_q  <= 8'h00;
    end else begin
      div_q   <= div_d;
      digit_q <= digit_d;
      com_q   <= com_d;
      data_q  <= data_d;
    end
  end

  assign com_o  = com_q;
  assign data_o = data_q;

endmodule

// File: rtl/term_project_top_spec.sv
// Button-driven 8-element dot-product calculator, FPGA top level.
//   CLK      : system clock
//   btn_sw   : raw active-low buttons; [0]=bit 0, [1]=bit 1, [2]=commit, [3]=reset
//   seg_COM  : active-low one-hot digit select
//   seg_DATA : {a..g, dp} active-high segments
module term_project_top_spec
  import term_project_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic       CLK,
  input  logic [7:0] btn_sw,
  output logic [7:0] seg_COM,
  output logic [7:0] seg_DATA
);

  logic unused_btn;
  assign unused_btn = ^btn_sw[7:4];

  // Reset: asserts asynchronously, releases after two clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge CLK or negedge btn_sw[BTN_D]) begin
    if (!btn_sw[BTN_D]) rst_sync_q <= 2'b00;
    else                rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Button synchroniser plus falling-edge detector; idle level is high.
  logic [2:0] sync1_q, sync2_q, prev_q, press;
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= btn_sw[2:0];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end
  assign press = prev_q & ~sync2_q;

  state_e                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [ELEM_W-1:0]       bit_sr_q, bit_sr_d;
  logic [ACC_W-1:0]        acc_q, acc_d, bin_q, bin_d;
  logic [BCD_DIGITS*4-1:0] bcd_q, bcd_d;
  logic [4:0]              conv_cnt_q, conv_cnt_d;
  logic [ELEM_W-1:0]       a_mem_q [N_ELEM];
  logic                    a_we;
  logic [2*ELEM_W-1:0]     prod;

  assign prod = a_mem_q[idx_q] * bit_sr_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bit_sr_d   = bit_sr_q;
    acc_d      = acc_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    conv_cnt_d = conv_cnt_q;
    a_we       = 1'b0;
    unique case (state_q)
      StEnterA, StEnterB: begin
        if (press[BTN_C]) begin
          bit_sr_d = '0;
          idx_d    = idx_q + 3'd1;
          if (state_q == StEnterA) begin
            a_we = 1'b1;
            if (idx_q == 3'd7) state_d = StEnterB;
          end else begin
            acc_d = acc_q + {{(ACC_W - 2*ELEM_W){1'b0}}, prod};
            if (idx_q == 3'd7) begin
              state_d    = StConvert;
              conv_cnt_d = '0;
            end
          end
        end else if (press[BTN_A] ^ press[BTN_B]) begin
          // A and B together cancel; B shifts in a 1, A a 0.
          bit_sr_d = {bit_sr_q[ELEM_W-2:0], press[BTN_B]};
        end
      end
      StConvert: begin
        conv_cnt_d = conv_cnt_q + 5'd1;
        if (conv_cnt_q == 5'd0) begin
          bin_d = acc_q;
          bcd_d = '0;
        end else begin
          {bcd_d, bin_d} = {bcd_add3(bcd_q), bin_q} << 1;
          if (conv_cnt_q == 5'(ACC_W)) state_d = StShow;
        end
      end
      StShow: ;
      default: state_d = StEnterA;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEnterA;
      idx_q      <= '0;
      bit_sr_q   <= '0;
      acc_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      conv_cnt_q <= '0;
      for (int i = 0; i < N_ELEM; i++) a_mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bit_sr_q   <= bit_sr_d;
      acc_q      <= acc_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      conv_cnt_q <= conv_cnt_d;
      if (a_we) a_mem_q[idx_q] <= bit_sr_q;
    end
  end

  // Digit codes for the scanner.
  logic [7:0][4:0] codes;
  logic            lead;
  always_comb begin
    lead = 1'b1;
    for (int i = 0; i < 8; i++) codes[i] = {1'b0, CODE_BLANK};
    unique case (state_q)
      StEnterA, StEnterB: begin
        for (int i = 0; i < 8; i++) codes[i] = {1'b0, 3'b000, bit_sr_q[i]};
        codes[7][4] = (state_q == StEnterB);
      end
      StShow: begin
        // Blank leading zeros from digit 5 downward; digit 0 always shows.
        for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
          if (lead && (bcd_q[4*i+:4] == 4'd0)) begin
            codes[i] = {1'b0, CODE_BLANK};
          end else begin
            lead     = 1'b0;
            codes[i] = {1'b0, bcd_q[4*i+:4]};
          end
        end
        codes[0] = {1'b0, bcd_q[3:0]};
      end
      default: ;
    endcase
  end

  seg7_scan #(
    .ScanDiv(SCAN_DIV)
  ) u_scan (
    .clk_i  (CLK),
    .rst_ni (rst_n),
    .codes_i(codes),
    .com_o  (seg_COM),
    .data_o (seg_DATA)
  );

endmodule

// File: tb/tb_term_project_top_spec.sv
module tb_term_project_top_spec;
  import term_project_pkg::*;

  localparam int unsigned SCAN = 16;
  localparam logic [7:0] D0 = 8'hFC, D1 = 8'h60, D2 = 8'hDA, D5 = 8'hB6, D6 = 8'hBE;

  logic       CLK;
  logic [7:0] btn_sw;
  logic [7:0] seg_COM, seg_DATA;
  logic [7:0] disp [8];
  int         n_checks = 0;
  int         n_errors = 0;

  term_project_top_spec #(.SCAN_DIV(SCAN)) dut (
    .CLK     (CLK),
    .btn_sw  (btn_sw),
    .seg_COM (seg_COM),
    .seg_DATA(seg_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [2:0] mask);
    @(negedge CLK);
    btn_sw[2:0] = ~mask;
    repeat (5) @(negedge CLK);
    btn_sw[2:0] = 3'b111;
    repeat (5) @(negedge CLK);
  endtask

  task automatic enter_elem(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) press(v[i] ? 3'b010 : 3'b001);
    press(3'b100);
  endtask

  task automatic enter_vec(input logic [7:0] first, input logic [7:0] rest);
    enter_elem(first);
    for (int i = 1; i < 8; i++) enter_elem(rest);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    btn_sw[3] = 1'b0;
    repeat (3) @(negedge CLK);
    btn_sw[3] = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic capture();
    for (int d = 0; d < 8; d++) disp[d] = 8'hxx;
    repeat (8 * SCAN + 4) begin
      @(negedge CLK);
      for (int d = 0; d < 8; d++) if (seg_COM == ~(8'b1 << d)) disp[d] = seg_DATA;
    end
  endtask

  task automatic wait_show();
    int n = 0;
    while (dut.state_q !== StShow && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_show", dut.state_q, StShow);
  endtask

  initial begin
    logic [7:0] prev;
    int hold, nchg, bad;
    btn_sw = 8'hF7;
    repeat (4) @(negedge CLK);
    chk("rst_com", seg_COM, 8'hFF);
    chk("rst_data", seg_DATA, 8'h00);
    btn_sw = 8'hFF;
    repeat (4) @(negedge CLK);
    chk("rst_state", dut.state_q, StEnterA);
    chk("rst_idx", dut.idx_q, 0);
    chk("rst_acc", dut.acc_q, 0);

    // Short entry: B,A,B -> 101, then commit as A[0].
    press(3'b010); press(3'b001); press(3'b010);
    capture();
    chk("short_d0", disp[0], D1);
    chk("short_d1", disp[1], D0);
    chk("short_d2", disp[2], D1);
    for (int d = 3; d < 8; d++) chk("short_hi", disp[d], D0);
    press(3'b100);
    chk("short_amem0", dut.a_mem_q[0], 8'd5);

    // Simultaneous presses.
    press(3'b010);
    press(3'b011);
    chk("ab_ignored", dut.bit_sr_q, 8'h01);
    press(3'b101);
    chk("ac_amem1", dut.a_mem_q[1], 8'd1);
    chk("ac_sr_clear", dut.bit_sr_q, 8'h00);
    chk("ac_idx", dut.idx_q, 2);
    enter_elem(8'd7);
    chk("three_idx", dut.idx_q, 3);

    // Reset mid-entry, checked before the next clock edge.
    @(negedge CLK);
    #2 btn_sw[3] = 1'b0;
    #1;
    chk("midrst_com", seg_COM, 8'hFF);
    chk("midrst_data", seg_DATA, 8'h00);
    chk("midrst_state", dut.state_q, StEnterA);
    chk("midrst_idx", dut.idx_q, 0);
    chk("midrst_amem1", dut.a_mem_q[1], 0);
    repeat (3) @(negedge CLK);
    btn_sw[3] = 1'b1;
    repeat (4) @(negedge CLK);

    // Re-entry A=(2,0..), B=(3,0..) -> 6; dp on digit 7 in ENTER_B.
    enter_vec(8'd2, 8'd0);
    chk("to_enter_b", dut.state_q, StEnterB);
    capture();
    chk("eb_d7_dp", disp[7], 8'hFD);
    chk("eb_d0", disp[0], D0);
    enter_vec(8'd3, 8'd0);
    wait_show();
    chk("reentry_acc", dut.acc_q, 6);
    capture();
    chk("reentry_d0", disp[0], D6);
    chk("reentry_d1", disp[1], 8'h00);

    // Basic dot product: A=(1,0..), B=(5,0..) -> 5.
    do_reset();
    enter_vec(8'd1, 8'd0);
    enter_vec(8'd5, 8'd0);
    wait_show();
    chk("basic_acc", dut.acc_q, 5);
    capture();
    chk("basic_d0", disp[0], D5);
    for (int d = 1; d < 8; d++) chk("basic_blank", disp[d], 8'h00);

    // SHOW ignores buttons.
    press(3'b001); press(3'b010); press(3'b100); press(3'b111);
    chk("show_hold_state", dut.state_q, StShow);
    chk("show_hold_acc", dut.acc_q, 5);
    chk("show_hold_sr", dut.bit_sr_q, 0);

    // Scan order and dwell.
    prev = seg_COM; hold = 0; nchg = 0; bad = 0;
    for (int c = 0; c < 8 * SCAN * 2; c++) begin
      @(negedge CLK);
      if ($countones(~seg_COM) != 1) bad++;
      if (seg_COM !== prev) begin
        chk("scan_order", seg_COM, {prev[6:0], prev[7]});
        if (nchg > 0) chk("scan_hold", hold, 16);
        nchg++;
        hold = 1;
        prev = seg_COM;
      end else begin
        hold++;
      end
    end
    chk("scan_onehot", bad, 0);
    chk("scan_changes", nchg, 16);

    // Maximum: all 255 -> 520200.
    do_reset();
    enter_vec(8'd255, 8'd255);
    enter_vec(8'd255, 8'd255);
    wait_show();
    chk("max_acc", dut.acc_q, 520200);
    capture();
    chk("max_d0", disp[0], D0);
    chk("max_d1", disp[1], D0);
    chk("max_d2", disp[2], D2);
    chk("max_d3", disp[3], D0);
    chk("max_d4", disp[4], D2);
    chk("max_d5", disp[5], D5);
    chk("max_d6", disp[6], 8'h00);
    chk("max_d7", disp[7], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
